// File: rtl/alu_exec_stage.sv
// Execute/writeback sequencer around an external 8-bit add/sub ALU.
// Owns the register file and the {V,C,Z,N} flags register.
module alu_exec_stage #(
  parameter int NUM_REGS  = 8,
  parameter int REG_IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 opValid,
  output logic                 opReady,
  input  logic [1:0]           opCode,
  input  logic [REG_IDX_W-1:0] rd,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic [7:0]           imm,
  output logic [7:0]           aluFirst,
  output logic [7:0]           aluSecond,
  output logic                 aluIsAdding,
  input  logic [7:0]           aluResult,
  input  logic                 aluOverflow,
  input  logic                 aluUnsignedOverflow,
  input  logic                 aluIsZero,
  input  logic                 aluSign,
  output logic [3:0]           flags,
  output logic                 done,
  input  logic [REG_IDX_W-1:0] dbgIdx,
  output logic [7:0]           dbgData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  state_t r_state;
  state_t w_next;

  logic [7:0]           r_regs [NUM_REGS];
  logic [1:0]           r_op;
  logic [REG_IDX_W-1:0] r_rd;
  logic [7:0]           r_imm;
  logic [7:0]           r_first;
  logic [7:0]           r_second;
  logic                 r_adding;
  logic [7:0]           r_res;
  logic [3:0]           r_hold;
  logic [3:0]           r_flags;

  logic       w_accept;
  logic       w_wr_reg;
  logic       w_wr_flags;
  logic [7:0] w_wr_data;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    opReady    = 1'b0;
    done       = 1'b0;
    w_accept   = 1'b0;
    w_wr_reg   = 1'b0;
    w_wr_flags = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        opReady = 1'b1;
        if (opValid) begin
          w_accept = 1'b1;
          w_next   = S_EXEC;
        end
      end
      S_EXEC: w_next = S_WB;
      S_WB: begin
        done       = 1'b1;
        w_wr_reg   = (r_op != OP_CMP);
        w_wr_flags = (r_op != OP_LDI);
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_wr_data = (r_op == OP_LDI) ? r_imm : r_res;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= 8'h00;
      r_op     <= OP_ADD;
      r_rd     <= '0;
      r_imm    <= 8'h00;
      r_first  <= 8'h00;
      r_second <= 8'h00;
      r_adding <= 1'b1;
      r_res    <= 8'h00;
      r_hold   <= 4'h0;
      r_flags  <= 4'h0;
    end else begin
      if (w_accept) begin
        r_op     <= opCode;
        r_rd     <= rd;
        r_imm    <= imm;
        r_first  <= r_regs[rs1];
        r_second <= r_regs[rs2];
        // LDI never consults the ALU; park it in add mode
        r_adding <= (opCode == OP_ADD) ||
                    (opCode == OP_LDI);
      end
      if (r_state == S_EXEC) begin
        r_res  <= aluResult;
        r_hold <= {aluOverflow,
                   aluUnsignedOverflow,
                   aluIsZero,
                   aluSign};
      end
      if (w_wr_reg)
        r_regs[r_rd] <= w_wr_data;
      if (w_wr_flags)
        r_flags <= r_hold;
    end
  end

  assign aluFirst    = r_first;
  assign aluSecond   = r_second;
  assign aluIsAdding = r_adding;
  assign flags       = r_flags;
  assign dbgData     = r_regs[dbgIdx];

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage with a behavioural ALU and
// an arithmetic reference model of registers and flags.
module tb_alu_exec_stage;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       opValid;
  logic       opReady;
  logic [1:0] opCode;
  logic [2:0] rd, rs1, rs2;
  logic [7:0] imm;
  logic [7:0] aluFirst, aluSecond;
  logic       aluIsAdding;
  logic [7:0] aluResult;
  logic       aluOverflow;
  logic       aluUnsignedOverflow;
  logic       aluIsZero;
  logic       aluSign;
  logic [3:0] flags;
  logic       done;
  logic [2:0] dbgIdx;
  logic [7:0] dbgData;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_regs [8];
  logic [3:0] m_flags;

  always #5 clk = ~clk;

  alu_exec_stage #(
    .NUM_REGS (8),
    .REG_IDX_W(3)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .opValid            (opValid),
    .opReady            (opReady),
    .opCode             (opCode),
    .rd                 (rd),
    .rs1                (rs1),
    .rs2                (rs2),
    .imm                (imm),
    .aluFirst           (aluFirst),
    .aluSecond          (aluSecond),
    .aluIsAdding        (aluIsAdding),
    .aluResult          (aluResult),
    .aluOverflow        (aluOverflow),
    .aluUnsignedOverflow(aluUnsignedOverflow),
    .aluIsZero          (aluIsZero),
    .aluSign            (aluSign),
    .flags              (flags),
    .done               (done),
    .dbgIdx             (dbgIdx),
    .dbgData            (dbgData)
  );

  // External combinational ALU
  logic [8:0] w_sum;
  logic       w_b7;
  assign w_sum = aluIsAdding ?
    {1'b0, aluFirst} + {1'b0, aluSecond} :
    {1'b0, aluFirst} + {1'b0, ~aluSecond} + 9'd1;
  assign w_b7 = aluIsAdding ? aluSecond[7] : ~aluSecond[7];
  assign aluResult           = w_sum[7:0];
  assign aluUnsignedOverflow = w_sum[8];
  assign aluOverflow = (aluFirst[7] == w_b7) &&
                       (w_sum[7] != aluFirst[7]);
  assign aluIsZero = (w_sum[7:0] == 8'h00);
  assign aluSign   = w_sum[7];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_flags = 4'h0;
  endtask

  task automatic model_apply(
    input logic [1:0] op,
    input logic [2:0] d,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] im
  );
    int s, ss;
    logic c, v;
    logic [7:0] r;
    if (op == OP_LDI) begin
      m_regs[d] = im;
      return;
    end
    if (op == OP_ADD) begin
      s  = int'(a) + int'(b);
      ss = int'($signed(a)) + int'($signed(b));
      c  = (s > 255);
    end else begin
      s  = int'(a) - int'(b);
      ss = int'($signed(a)) - int'($signed(b));
      c  = (a >= b);
    end
    r = s[7:0];
    v = (ss > 127) || (ss < -128);
    m_flags = {v, c, (r == 8'h00), r[7]};
    if (op != OP_CMP) m_regs[d] = r;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbgIdx = 3'(i);
      #1;
      checks++;
      if (dbgData !== m_regs[i]) begin
        errors++;
        $display("FAIL %s reg%0d: got %h want %h",
                 tag, i, dbgData, m_regs[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic run_op(
    input logic [1:0] op,
    input logic [2:0] d,
    input logic [2:0] s1,
    input logic [2:0] s2,
    input logic [7:0] im
  );
    int n;
    logic [7:0] ea, eb;
    logic       eadd;
    opCode  = op;
    rd      = d;
    rs1     = s1;
    rs2     = s2;
    imm     = im;
    opValid = 1'b1;
    n = 0;
    while (!opReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (opReady !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: opReady %b want 1",
               opReady);
      opValid = 1'b0;
      return;
    end
    ea   = m_regs[s1];
    eb   = m_regs[s2];
    eadd = (op == OP_ADD) || (op == OP_LDI);
    @(negedge clk);
    opValid = 1'b0;
    checks++;
    if (opReady !== 1'b0 || done !== 1'b0 ||
        aluFirst !== ea || aluSecond !== eb ||
        aluIsAdding !== eadd) begin
      errors++;
      $display("FAIL exec op%0d: rdy %b done %b a %h b %h add %b want 0 0 %h %h %b",
               op, opReady, done, aluFirst, aluSecond,
               aluIsAdding, ea, eb, eadd);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || opReady !== 1'b0) begin
      errors++;
      $display("FAIL wb_done: done %b rdy %b want 1 0",
               done, opReady);
    end
    model_apply(op, d, ea, eb, im);
    @(negedge clk);
    dbgIdx = d;
    #1;
    checks++;
    if (done !== 1'b0 || opReady !== 1'b1 ||
        dbgData !== m_regs[d] || flags !== m_flags) begin
      errors++;
      $display("FAIL result op%0d r%0d: done %b rdy %b data %h flags %b want 0 1 %h %b",
               op, d, done, opReady, dbgData, flags,
               m_regs[d], m_flags);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    opValid = 1'b0;
    opCode  = OP_ADD;
    rd      = 3'd0;
    rs1     = 3'd0;
    rs2     = 3'd0;
    imm     = 8'h00;
    dbgIdx  = 3'd0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (opReady !== 1'b1 || done !== 1'b0 ||
        flags !== 4'h0 || aluFirst !== 8'h00 ||
        aluSecond !== 8'h00 || aluIsAdding !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: rdy %b done %b flags %b a %h b %h add %b want 1 0 0000 00 00 1",
               opReady, done, flags, aluFirst, aluSecond,
               aluIsAdding);
    end
    check_all_regs("reset_regs");
  endtask

  task automatic test_add_overflow();
    run_op(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h7F);
    run_op(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h01);
    run_op(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00);
    dbgIdx = 3'd3;
    #1;
    checks++;
    if (dbgData !== 8'h80 || flags !== 4'b1001) begin
      errors++;
      $display("FAIL add_overflow: r3 %h flags %b want 80 1001",
               dbgData, flags);
    end
  endtask

  task automatic test_sub_zero();
    run_op(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h05);
    run_op(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h05);
    run_op(OP_SUB, 3'd4, 3'd1, 3'd2, 8'h00);
    dbgIdx = 3'd4;
    #1;
    checks++;
    if (dbgData !== 8'h00 || flags !== 4'b0110) begin
      errors++;
      $display("FAIL sub_zero: r4 %h flags %b want 00 0110",
               dbgData, flags);
    end
  endtask

  task automatic test_cmp();
    run_op(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h03);
    run_op(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h05);
    run_op(OP_CMP, 3'd6, 3'd1, 3'd2, 8'h00);
    checks++;
    if (flags !== 4'b0001) begin
      errors++;
      $display("FAIL cmp_flags: %b want 0001", flags);
    end
    check_all_regs("cmp_regs");
  endtask

  task automatic test_self_add();
    run_op(OP_LDI, 3'd1, 3'd0, 3'd0, 8'hFF);
    run_op(OP_ADD, 3'd1, 3'd1, 3'd1, 8'h00);
    dbgIdx = 3'd1;
    #1;
    checks++;
    if (dbgData !== 8'hFE || flags !== 4'b0101) begin
      errors++;
      $display("FAIL self_add: r1 %h flags %b want FE 0101",
               dbgData, flags);
    end
    run_op(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h00);
    checks++;
    if (flags !== 4'b0101) begin
      errors++;
      $display("FAIL ldi_keeps_flags: %b want 0101", flags);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ea, eb;
    @(negedge clk);
    opCode  = OP_ADD;
    rd      = 3'd6;
    rs1     = 3'd3;
    rs2     = 3'd4;
    opValid = 1'b1;
    ea = m_regs[3];
    eb = m_regs[4];
    @(negedge clk);
    opCode = OP_LDI;
    rd     = 3'd7;
    imm    = 8'h5A;
    checks++;
    if (opReady !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_exec: rdy %b done %b want 0 0",
               opReady, done);
    end
    @(negedge clk);
    checks++;
    if (opReady !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wb: rdy %b done %b want 0 1",
               opReady, done);
    end
    model_apply(OP_ADD, 3'd6, ea, eb, 8'h00);
    @(negedge clk);
    dbgIdx = 3'd6;
    #1;
    checks++;
    if (opReady !== 1'b1 || done !== 1'b0 ||
        dbgData !== m_regs[6]) begin
      errors++;
      $display("FAIL b2b_idle: rdy %b done %b r6 %h want 1 0 %h",
               opReady, done, dbgData, m_regs[6]);
    end
    @(negedge clk);
    opValid = 1'b0;
    checks++;
    if (opReady !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_accept: rdy %b done %b want 0 0",
               opReady, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done: %b want 1", done);
    end
    model_apply(OP_LDI, 3'd7, 8'h00, 8'h00, 8'h5A);
    @(negedge clk);
    dbgIdx = 3'd7;
    #1;
    checks++;
    if (dbgData !== 8'h5A) begin
      errors++;
      $display("FAIL b2b_r7: %h want 5A", dbgData);
    end
  endtask

  task automatic test_reset_mid();
    run_op(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h11);
    run_op(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h22);
    opCode  = OP_ADD;
    rd      = 3'd5;
    rs1     = 3'd1;
    rs2     = 3'd2;
    opValid = 1'b1;
    @(negedge clk);
    opValid = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_done: %b want 0", done);
    end
    model_reset();
    @(negedge clk);
    checks++;
    if (opReady !== 1'b1 || done !== 1'b0 ||
        flags !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_state: rdy %b done %b flags %b want 1 0 0000",
               opReady, done, flags);
    end
    check_all_regs("reset_mid_regs");
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(2'($urandom_range(0, 3)),
             3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)),
             8'($urandom_range(0, 255)));
    end
    check_all_regs("random_regs");
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_cmp();
    test_self_add();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Multi-cycle execute/writeback sequencer wrapped around the combinational 8-bit add/sub ALU. Holds the register file and the flags register.
- Accepts one operation at a time over a valid/ready handshake. Registers the ALU operands, captures the ALU result and flags, then writes back.
- Upstream is instruction decode. Downstream is the ALU's result/flag bus, which this block consumes.

Parameters:
- NUM_REGS, 8, number of 8-bit general registers (power of 2, 2..16).
- REG_IDX_W, 3, register index width; must equal log2(NUM_REGS).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- opValid  input  1  decode presents an operation.
- opReady  output  1  block can accept an operation (high only in IDLE).
- opCode  input  2  00 ADD, 01 SUB, 10 CMP, 11 LDI.
- rd  input  REG_IDX_W  destination register.
- rs1  input  REG_IDX_W  first source register.
- rs2  input  REG_IDX_W  second source register.
- imm  input  8  immediate value for LDI.
- aluFirst  output  8  registered first ALU operand.
- aluSecond  output  8  registered second ALU operand.
- aluIsAdding  output  1  1 = add, 0 = subtract.
- aluResult  input  8  ALU sum/difference.
- aluOverflow  input  1  ALU signed overflow.
- aluUnsignedOverflow  input  1  ALU carry out.
- aluIsZero  input  1  ALU zero flag.
- aluSign  input  1  ALU sign flag.
- flags  output  4  {V, C, Z, N} flags register.
- done  output  1  one-cycle pulse when writeback completes.
- dbgIdx  input  REG_IDX_W  debug read index.
- dbgData  output  8  combinational read of register dbgIdx.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; all registers = 0; flags = 0; aluFirst = aluSecond = 0; aluIsAdding = 1; done = 0; opReady = 1 on the first cycle after reset.
- Reset asserted mid-operation aborts that operation: no writeback, no done pulse.
- State machine has three states: IDLE, EXEC, WB.
- IDLE:
  - opReady = 1.
  - Handshake fires when opValid && opReady. On that edge, latch opCode, rd and imm; load aluFirst = reg[rs1] and aluSecond = reg[rs2].
  - Set aluIsAdding = 1 for ADD and 0 for SUB/CMP. For LDI, aluIsAdding is don't-care and is held at 1.
  - Next state: EXEC. LDI also goes to EXEC so latency is uniform.
- EXEC:
  - opReady = 0. ALU outputs settle combinationally from the registered operands.
  - On the edge: capture aluResult and the four flags into internal holding registers. Next state: WB.
- WB:
  - ADD/SUB: reg[rd] = captured result; flags = {V, C, Z, N} captured.
  - CMP: flags updated only; no register write.
  - LDI: reg[rd] = imm; flags unchanged.
  - done = 1 for exactly this cycle. Next state: IDLE.
- Latency and throughput: 3 cycles from accept to done. Maximum throughput is one operation every 3 cycles. opValid while busy is ignored; decode must hold it.
- Operand hazard: sources are read at accept. The previous op's writeback completes in WB, before the next accept, so back-to-back dependent ops always see the updated value.
- rs1 == rs2 == rd is legal. Example: ADD r1,r1,r1 doubles r1.
- C flag is the raw ALU carry out. For SUB it is 1 when no borrow occurs: 5-3 gives C=1, 3-5 gives C=0.
- Arithmetic wraps modulo 256; overflow is reported only through flags.
- dbgData is combinational; a write in WB is visible on the following cycle.

Test Plan:
- Reset, then LDI r1,0x7F and LDI r2,0x01, then ADD r3,r1,r2 -> r3=0x80, flags {V=1, C=0, Z=0, N=1}; done exactly 3 cycles after each accept.
- LDI r1,0x05, LDI r2,0x05, SUB r4,r1,r2 -> r4=0x00, flags {V=0, C=1, Z=1, N=0}.
- LDI r1,0x03, LDI r2,0x05, CMP r1,r2 -> flags {V=0, C=0, Z=0, N=1}; every register unchanged (check via dbgData).
- ADD r1,r1,r1 with r1=0xFF -> r1=0xFE, C=1; then LDI r1,0x00 -> flags unchanged (still C=1).
- Hold opValid high continuously during an ADD -> opReady low in EXEC/WB; the second op is accepted only on the cycle after done.
- Assert reset during EXEC of ADD r5,... -> no done pulse, r5=0, flags=0, opReady=1 the cycle after reset deasserts.
